shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Iterating controller directly upstream of the 4-bit combinational barrel shifter.
- Accepts a command of {data word, 2-bit shift code, repeat count} over a valid/ready handshake.
- Drives the shifter with its own accumulator, feeding the shifter result back for `count` cycles, then presents the final word on a valid/ready output.
- Does not interpret the shift code; it forwards the code unchanged every iteration.

Parameters:
- WIDTH, 4, data word width; must match the shifter data width.
- CNT_W, 3, repeat-count width; max iterations = 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid & in_ready at a clk edge.
- in_data  input  WIDTH  initial word.
- in_shift  input  2  shift code forwarded to the shifter.
- in_count  input  CNT_W  number of shifter passes (0..2^CNT_W-1).
- shf_data  output  WIDTH  to shifter data input (registered accumulator).
- shf_shift  output  2  to shifter shift input (registered).
- shf_result  input  WIDTH  from shifter result output (combinational return path).
- out_valid  output  1  final word valid.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  final word.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock domain, clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE
  - acc (=shf_data)=0, shf_shift=2'b00, remaining=0
  - out_valid=0, out_data=0, busy=0, in_ready=0
- in_ready is registered. It rises on the first clk edge after rst_n deasserts. Thereafter in_ready=1 exactly when state=IDLE.
- IDLE:
  - On in_valid & in_ready: acc<=in_data, shf_shift<=in_shift, remaining<=in_count, in_ready<=0.
  - Next state is RUN if in_count!=0, else DONE.
  - in_valid without in_ready has no effect.
- RUN:
  - Each edge: acc<=shf_result, remaining<=remaining-1.
  - When remaining==1 at the edge, go to DONE.
  - RUN therefore lasts exactly in_count cycles.
  - shf_shift is held constant for the whole command.
- DONE:
  - out_valid=1, out_data=acc. Both are held stable until out_ready.
  - On out_valid & out_ready: out_valid<=0, state<=IDLE, in_ready<=1.
  - No back-to-back acceptance in the same cycle; one bubble cycle in IDLE is required.
- Latency, measured from accept edge E0 to out_valid high:
  - count=0: out_valid high in the cycle after E0; out_data=in_data.
  - count=N: out_valid high after edge E0+N.
  - out_valid, out_data and busy are registered outputs.
- In IDLE, shf_data keeps the last acc value and shf_shift keeps the last code. The downstream shifter result is ignored outside RUN.
- out_data is a registered copy of acc, updated on the edge entering DONE.
- No decrement occurs outside RUN. remaining never underflows.
- Reset mid-operation: any state returns immediately (asynchronously) to the reset values; the in-flight command is discarded. No output pulse is generated on release.
- in_data/in_shift/in_count are sampled only on the accept edge; later changes are ignored.
- X on in_* while in_valid=0 must not propagate to any output.

Optional Feature:
- Macro: SHIFT_SEQ_CTRL_STATS_EN.
- Defined:
  - Adds output stat_cmds [15:0], reset 0. It increments on each out_valid & out_ready handshake and saturates at 16'hFFFF.
  - Adds output stat_iters [15:0], reset 0. It increments on every RUN cycle and saturates at 16'hFFFF.
- Undefined: neither port exists and no counter logic is present. All other behaviour is identical.

Test Plan:
- Reset release → in_ready=0 during reset and on the first edge after, then 1; all other outputs 0 → transaction cmd{data=4'b1001, shift=2'b01, count=0} → out_valid in the next cycle, out_data=4'b1001, shf_shift=2'b01.
- cmd{data=4'b0001, shift=2'b01, count=3} with the real shifter attached → shf_data sequence 0001, 0010, 0100; out_data=4'b1000 after 3 RUN cycles; busy high for 4 cycles with out_ready=1.
- cmd{data=4'b1000, shift=2'b11, count=7} → shf_shift=2'b11 held for 7 cycles; out_data=4'b0001 (7 rotate-right passes = 1 rotate-left pass).
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and in_data → out_data stable, in_ready=0, no new command accepted; out_ready=1 → IDLE, in_ready=1 one cycle later.
- Assert rst_n=0 midway through count=5 → outputs zero asynchronously; after release, a new cmd{data=4'b0110, shift=2'b00, count=2} returns 4'b0110. With SHIFT_SEQ_CTRL_STATS_EN defined: stat_cmds=1, stat_iters=2.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// Command and result handshake bundle for shift_seq_ctrl.
// Command side: in_valid/in_ready carrying {in_data, in_shift, in_count}.
// Result side: out_valid/out_ready carrying out_data.
// The master drives commands and accepts results; the slave is the controller.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_shift;
  logic [CNT_W-1:0] in_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output in_shift,
    output in_count,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_shift,
    input  in_count,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: iterating controller sitting in front of a combinational
// barrel shifter. A command {data, shift code, count} is loaded into an
// accumulator that drives the shifter; the shifter result is fed back into
// the accumulator for `count` cycles and the final word is then presented on
// the result handshake. The shift code is forwarded untouched.
//
// Optional build macro SHIFT_SEQ_CTRL_STATS_EN adds two saturating 16-bit
// counters: stat_cmds (completed result handshakes) and stat_iters (RUN
// cycles). With the macro undefined neither port nor counter exists.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_seq_ctrl_if.slave  cmd_if,
  output logic [WIDTH-1:0] shf_data,
  output logic [1:0]       shf_shift,
  input  logic [WIDTH-1:0] shf_result,
  output logic             busy
`ifdef SHIFT_SEQ_CTRL_STATS_EN
  ,
  output logic [15:0]      stat_cmds,
  output logic [15:0]      stat_iters
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_acc;
  logic [1:0]       r_shift;
  logic [CNT_W-1:0] r_remaining;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_busy;

  logic             w_accept;
  logic             w_out_hs;
  logic             w_last_iter;
  logic             w_load_cmd;
  logic             w_iter;
  logic             w_enter_done;
  logic [WIDTH-1:0] w_acc_nxt;

  // in_ready is registered, so an accept can only happen in IDLE.
  assign w_accept    = cmd_if.in_valid & r_in_ready;
  assign w_out_hs    = r_out_valid & cmd_if.out_ready;
  // Treat a zero count as "last" too, so RUN can never decrement past zero.
  assign w_last_iter = (r_remaining <= CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the load/iterate strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_load_cmd  = 1'b0;
    w_iter      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_load_cmd  = 1'b1;
          w_state_nxt = (cmd_if.in_count != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        w_iter = 1'b1;
        if (w_last_iter) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_out_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // out_data must capture the value the accumulator takes on the DONE entry
  // edge, so the next accumulator value is formed once and shared.
  always_comb begin
    w_acc_nxt = r_acc;
    if (w_load_cmd) begin
      w_acc_nxt = cmd_if.in_data;
    end else if (w_iter) begin
      w_acc_nxt = shf_result;
    end
  end

  assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  // Accumulator, shift code and iteration counter; shifter result is only
  // consumed while in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_shift     <= 2'b00;
      r_remaining <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      if (w_load_cmd) begin
        r_shift     <= cmd_if.in_shift;
        r_remaining <= cmd_if.in_count;
      end else if (w_iter && (r_remaining != '0)) begin
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  // Handshake and status outputs, all registered from the next state so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_in_ready <= (w_state_nxt == S_IDLE);
      r_busy     <= (w_state_nxt != S_IDLE);
      if (w_enter_done) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_acc_nxt;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef SHIFT_SEQ_CTRL_STATS_EN
  logic [15:0] r_stat_cmds;
  logic [15:0] r_stat_iters;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // Completed-command and RUN-cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_cmds  <= '0;
      r_stat_iters <= '0;
    end else begin
      if (w_out_hs) begin
        r_stat_cmds <= sat_inc(r_stat_cmds);
      end
      if (w_iter) begin
        r_stat_iters <= sat_inc(r_stat_iters);
      end
    end
  end

  assign stat_cmds  = r_stat_cmds;
  assign stat_iters = r_stat_iters;
`endif

  assign cmd_if.in_ready  = r_in_ready;
  assign cmd_if.out_valid = r_out_valid;
  assign cmd_if.out_data  = r_out_data;
  assign shf_data         = r_acc;
  assign shf_shift        = r_shift;
  assign busy             = r_busy;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl with a behavioural 4-bit barrel shifter on the
// return path. Expected final words are pushed to a queue at each command
// accept and popped when the result handshake completes.
module tb_shift_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] shf_data;
  logic [WIDTH-1:0] shf_result;
  logic [1:0]       shf_shift;
  logic             busy;
`ifdef SHIFT_SEQ_CTRL_STATS_EN
  logic [15:0]      stat_cmds;
  logic [15:0]      stat_iters;
`endif

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] mon_exp;

  shift_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

  shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_if     (cmd_if),
    .shf_data   (shf_data),
    .shf_shift  (shf_shift),
    .shf_result (shf_result),
    .busy       (busy)
`ifdef SHIFT_SEQ_CTRL_STATS_EN
    ,
    .stat_cmds  (stat_cmds),
    .stat_iters (stat_iters)
`endif
  );

  always #5 clk = ~clk;

  // Shifter: 00 pass, 01 rotate left 1, 10 logical right 1, 11 rotate right 1.
  function automatic logic [3:0] shf_model(input logic [3:0] d, input logic [1:0] s);
    case (s)
      2'b00:   return d;
      2'b01:   return {d[2:0], d[3]};
      2'b10:   return {1'b0, d[3:1]};
      default: return {d[0], d[3:1]};
    endcase
  endfunction

  function automatic logic [3:0] exp_result(input logic [3:0] d, input logic [1:0] s,
                                            input logic [2:0] n);
    logic [3:0] v;
    v = d;
    for (int k = 0; k < int'(n); k++) v = shf_model(v, s);
    return v;
  endfunction

  assign shf_result = shf_model(shf_data, shf_shift);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && cmd_if.out_valid && cmd_if.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_out", sb_q.size(), 1);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("sb_out_data", cmd_if.out_data, mon_exp);
        n_out++;
      end
    end
  end

  task automatic idle_inputs();
    cmd_if.in_valid = 1'b0;
    cmd_if.in_data  = 'x;
    cmd_if.in_shift = 'x;
    cmd_if.in_count = 'x;
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [3:0] d, input logic [1:0] s, input logic [2:0] n);
    int t;
    t = 0;
    cmd_if.in_valid = 1'b1;
    cmd_if.in_data  = d;
    cmd_if.in_shift = s;
    cmd_if.in_count = n;
    while (!cmd_if.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("send_in_ready", cmd_if.in_ready, 1);
    if (cmd_if.in_ready) begin
      @(posedge clk); #1;
      sb_q.push_back(exp_result(d, s, n));
    end
    idle_inputs();
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || !cmd_if.in_ready) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq2 [3];
    int nb;
    int nheld;
    int t;
    seq2 = '{4'b0001, 4'b0010, 4'b0100};

    idle_inputs();
    cmd_if.out_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  cmd_if.in_ready,  0);
    chk("rst_out_valid", cmd_if.out_valid, 0);
    chk("rst_out_data",  cmd_if.out_data,  0);
    chk("rst_busy",      busy,             0);
    chk("rst_shf_data",  shf_data,         0);
    chk("rst_shf_shift", shf_shift,        0);
`ifdef SHIFT_SEQ_CTRL_STATS_EN
    chk("rst_stat_cmds",  stat_cmds,  0);
    chk("rst_stat_iters", stat_iters, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", cmd_if.in_ready, 0);
    @(posedge clk); #1;
    chk("rel_in_ready_post", cmd_if.in_ready, 1);

    // count = 0: result in the cycle after accept
    send(4'b1001, 2'b01, 3'd0);
    chk("t1_out_valid", cmd_if.out_valid, 1);
    chk("t1_out_data",  cmd_if.out_data,  4'b1001);
    chk("t1_shf_shift", shf_shift,        2'b01);
    chk("t1_busy",      busy,             1);
    chk("t1_in_ready",  cmd_if.in_ready,  0);
    wait_done();

    // count = 3 rotate-left: accumulator walks 0001, 0010, 0100 then 1000
    send(4'b0001, 2'b01, 3'd3);
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) chk($sformatf("t2_shf_data%0d", i), shf_data, seq2[i]);
      if (i == 3) begin
        chk("t2_out_valid", cmd_if.out_valid, 1);
        chk("t2_out_data",  cmd_if.out_data,  4'b1000);
      end
      if (busy) nb++;
      @(posedge clk); #1;
    end
    chk("t2_busy_cycles", nb, 4);

    // count = 7 rotate-right: code held through all of RUN
    send(4'b1000, 2'b11, 3'd7);
    nheld = 0;
    for (int i = 0; i < 7; i++) begin
      if (shf_shift == 2'b11 && !cmd_if.out_valid) nheld++;
      @(posedge clk); #1;
    end
    chk("t3_held_cycles", nheld, 7);
    chk("t3_out_valid",   cmd_if.out_valid, 1);
    chk("t3_out_data",    cmd_if.out_data,  4'b0001);
    wait_done();

    // Back-pressure in DONE with in_valid/in_data toggling
    cmd_if.out_ready = 1'b0;
    send(4'b0011, 2'b01, 3'd1);
    t = 0;
    while (!cmd_if.out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("t4_out_valid", cmd_if.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cmd_if.in_valid = ~cmd_if.in_valid;
      cmd_if.in_data  = 4'($urandom);
      cmd_if.in_shift = 2'b10;
      cmd_if.in_count = 3'd1;
      @(posedge clk); #1;
      chk($sformatf("t4_hold_data%0d", i),  cmd_if.out_data, 4'b0110);
      chk($sformatf("t4_hold_ready%0d", i), cmd_if.in_ready, 0);
    end
    idle_inputs();
    cmd_if.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_rel_out_valid", cmd_if.out_valid, 0);
    chk("t4_rel_in_ready",  cmd_if.in_ready,  1);
    chk("t4_rel_busy",      busy,             0);
    wait_done();

    // Asynchronous reset in the middle of a count = 5 command
    send(4'b0101, 2'b01, 3'd5);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", cmd_if.out_valid, 0);
    chk("t5_rst_out_data",  cmd_if.out_data,  0);
    chk("t5_rst_busy",      busy,             0);
    chk("t5_rst_shf_data",  shf_data,         0);
    chk("t5_rst_shf_shift", shf_shift,        0);
    chk("t5_rst_in_ready",  cmd_if.in_ready,  0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'b0110, 2'b00, 3'd2);
    wait_done();
`ifdef SHIFT_SEQ_CTRL_STATS_EN
    chk("t5_stat_cmds",  stat_cmds,  1);
    chk("t5_stat_iters", stat_iters, 2);
`endif

    chk("total_outputs", n_out, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
